axi_wr_burst_ctrl: RTL and testbench

- Write-side sequencer in front of axi_data_packer.
- Pops burst descriptors (address + len/size) from the burst FIFO and issues them on the AXI AW channel.
- Starts the packer for each burst, tracks W completion, and limits bursts outstanding without a B response.
- Consumes B responses and keeps error status.

---
 rtl/axi_wr_burst_ctrl.sv | 179 +++++++++++++++++
 tb/tb_axi_wr_burst_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_wr_burst_ctrl.sv
// AXI write-burst sequencer: pops burst descriptors, issues AW, starts the
// data packer, tracks W completion and B responses, and keeps error status.
module axi_wr_burst_ctrl #(
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned ERR_CNT_W       = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 b_empty,
  output logic                 b_pop,
  input  logic [31:0]          burst_addr,
  input  logic [11:0]          burst_info,
  output logic                 axi_awvalid,
  input  logic                 axi_awready,
  output logic [31:0]          axi_awaddr,
  output logic [7:0]           axi_awlen,
  output logic [2:0]           axi_awsize,
  output logic [1:0]           axi_awburst,
  output logic                 pk_start,
  output logic [8:0]           pk_beats,
  input  logic                 axi_wvalid,
  input  logic                 axi_wready,
  input  logic                 axi_wlast,
  input  logic                 axi_bvalid,
  output logic                 axi_bready,
  input  logic [1:0]           axi_bresp,
  output logic [3:0]           outstanding,
  output logic                 busy,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic                 err_sticky,
  input  logic                 clr_err
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADDR = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;

  localparam logic [3:0] MAX_OUT = 4'(MAX_OUTSTANDING);

  logic [1:0]           state_q,       state_d;
  logic [31:0]          awaddr_q,      awaddr_d;
  logic [7:0]           awlen_q,       awlen_d;
  logic [2:0]           awsize_q,      awsize_d;
  logic                 awvalid_q,     awvalid_d;
  logic                 pk_start_q,    pk_start_d;
  logic [8:0]           pk_beats_q,    pk_beats_d;
  logic [8:0]           beat_cnt_q,    beat_cnt_d;
  logic [3:0]           outstanding_q, outstanding_d;
  logic [ERR_CNT_W-1:0] err_cnt_q,     err_cnt_d;
  logic                 err_sticky_q,  err_sticky_d;

  logic       pop;
  logic       aw_hs;
  logic       w_hs;
  logic       b_hs;
  logic       w_err;
  logic [8:0] beat_next;
  logic [8:0] exp_beats;
  logic       unused_info;

  assign unused_info = burst_info[11];

  assign aw_hs     = awvalid_q & axi_awready;
  assign w_hs      = axi_wvalid & axi_wready;
  assign b_hs      = axi_bvalid & axi_bready;
  assign beat_next = beat_cnt_q + 9'd1;
  // awlen_q stays put until the next pop, which only happens back in IDLE
  assign exp_beats = {1'b0, awlen_q} + 9'd1;

  always_comb begin
    state_d    = state_q;
    awaddr_d   = awaddr_q;
    awlen_d    = awlen_q;
    awsize_d   = awsize_q;
    awvalid_d  = awvalid_q;
    pk_start_d = 1'b0;
    pk_beats_d = '0;
    beat_cnt_d = beat_cnt_q;
    pop        = 1'b0;
    w_err      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!rst && !b_empty && (outstanding_q < MAX_OUT)) begin
          pop       = 1'b1;
          awaddr_d  = burst_addr;
          awlen_d   = burst_info[7:0];
          awsize_d  = burst_info[10:8];
          awvalid_d = 1'b1;
          state_d   = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (aw_hs) begin
          awvalid_d  = 1'b0;
          pk_start_d = 1'b1;
          pk_beats_d = exp_beats;
          beat_cnt_d = '0;
          state_d    = ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_hs) begin
          beat_cnt_d = beat_next;
          if (axi_wlast) begin
            state_d = ST_IDLE;
            w_err   = (beat_next != exp_beats);
          end else begin
            w_err   = (beat_next == exp_beats);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    outstanding_d = outstanding_q;
    case ({aw_hs, b_hs})
      2'b10:   outstanding_d = outstanding_q + 4'd1;
      2'b01:   outstanding_d = outstanding_q - 4'd1;
      default: outstanding_d = outstanding_q;
    endcase
  end

  // Clear takes effect first so a coincident error event still lands
  always_comb begin
    err_cnt_d    = clr_err ? '0 : err_cnt_q;
    err_sticky_d = clr_err ? 1'b0 : err_sticky_q;
    if (b_hs && axi_bresp[1]) begin
      err_sticky_d = 1'b1;
      if (err_cnt_d != '1) err_cnt_d = err_cnt_d + ERR_CNT_W'(1);
    end
    if (w_err || (axi_bvalid && !axi_bready)) err_sticky_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      awaddr_q      <= '0;
      awlen_q       <= '0;
      awsize_q      <= '0;
      awvalid_q     <= 1'b0;
      pk_start_q    <= 1'b0;
      pk_beats_q    <= '0;
      beat_cnt_q    <= '0;
      outstanding_q <= '0;
      err_cnt_q     <= '0;
      err_sticky_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      awaddr_q      <= awaddr_d;
      awlen_q       <= awlen_d;
      awsize_q      <= awsize_d;
      awvalid_q     <= awvalid_d;
      pk_start_q    <= pk_start_d;
      pk_beats_q    <= pk_beats_d;
      beat_cnt_q    <= beat_cnt_d;
      outstanding_q <= outstanding_d;
      err_cnt_q     <= err_cnt_d;
      err_sticky_q  <= err_sticky_d;
    end
  end

  assign b_pop       = pop;
  assign axi_awvalid = awvalid_q;
  assign axi_awaddr  = awaddr_q;
  assign axi_awlen   = awlen_q;
  assign axi_awsize  = awsize_q;
  assign axi_awburst = 2'b01;
  assign pk_start    = pk_start_q;
  assign pk_beats    = pk_beats_q;
  assign axi_bready  = (outstanding_q != 4'd0);
  assign outstanding = outstanding_q;
  assign busy        = (state_q != ST_IDLE) || (outstanding_q != 4'd0);
  assign err_cnt     = err_cnt_q;
  assign err_sticky  = err_sticky_q;

endmodule

// File: tb/tb_axi_wr_burst_ctrl.sv
// Directed bench for axi_wr_burst_ctrl with a small show-ahead descriptor FIFO model.
module tb_axi_wr_burst_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        b_empty;
  logic        b_pop;
  logic [31:0] burst_addr;
  logic [11:0] burst_info;
  logic        axi_awvalid;
  logic        axi_awready;
  logic [31:0] axi_awaddr;
  logic [7:0]  axi_awlen;
  logic [2:0]  axi_awsize;
  logic [1:0]  axi_awburst;
  logic        pk_start;
  logic [8:0]  pk_beats;
  logic        axi_wvalid;
  logic        axi_wready;
  logic        axi_wlast;
  logic        axi_bvalid;
  logic        axi_bready;
  logic [1:0]  axi_bresp;
  logic [3:0]  outstanding;
  logic        busy;
  logic [7:0]  err_cnt;
  logic        err_sticky;
  logic        clr_err;

  logic [31:0] addr_mem [64];
  logic [11:0] info_mem [64];
  int          wr_ptr = 0;
  int          rd_ptr = 0;
  int          pop_cnt = 0;
  int          aw_cnt = 0;
  int          n_checks = 0;
  int          n_fails = 0;
  int          pop_base;
  int          aw_base;

  always #5 clk = ~clk;

  axi_wr_burst_ctrl #(
    .MAX_OUTSTANDING(4),
    .ERR_CNT_W(8)
  ) dut (
    .clk(clk), .rst(rst),
    .b_empty(b_empty), .b_pop(b_pop),
    .burst_addr(burst_addr), .burst_info(burst_info),
    .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
    .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen),
    .axi_awsize(axi_awsize), .axi_awburst(axi_awburst),
    .pk_start(pk_start), .pk_beats(pk_beats),
    .axi_wvalid(axi_wvalid), .axi_wready(axi_wready), .axi_wlast(axi_wlast),
    .axi_bvalid(axi_bvalid), .axi_bready(axi_bready), .axi_bresp(axi_bresp),
    .outstanding(outstanding), .busy(busy),
    .err_cnt(err_cnt), .err_sticky(err_sticky), .clr_err(clr_err)
  );

  assign b_empty    = (rd_ptr == wr_ptr);
  assign burst_addr = addr_mem[rd_ptr[5:0]];
  assign burst_info = info_mem[rd_ptr[5:0]];

  always @(posedge clk) begin
    if (b_pop) begin
      rd_ptr  <= rd_ptr + 1;
      pop_cnt <= pop_cnt + 1;
    end
    if (axi_awvalid && axi_awready) aw_cnt <= aw_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] a, input logic [11:0] i);
    addr_mem[wr_ptr[5:0]] = a;
    info_mem[wr_ptr[5:0]] = i;
    wr_ptr++;
    #1;
  endtask

  task automatic set_w(input logic v);
    axi_wvalid = v;
    axi_wready = v;
    axi_wlast  = v;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; axi_awready = 1'b0; set_w(1'b0);
    axi_bvalid = 1'b0; axi_bresp = 2'b00; clr_err = 1'b0;
    tick(); tick();
    check("rst_awvalid", axi_awvalid, 0);
    check("rst_awburst", axi_awburst, 1);
    check("rst_outstanding", outstanding, 0);
    check("rst_busy", busy, 0);
    check("rst_err", {err_sticky, err_cnt}, 0);
    check("rst_pk", {pk_start, pk_beats}, 0);
    check("rst_bready", axi_bready, 0);
    check("rst_awaddr", axi_awaddr, 0);
    rst = 1'b0;

    // basic 5-beat burst
    push(32'hDEAD0000, 12'h204);
    check("t1_pop", b_pop, 1);
    tick();
    check("t1_pop_once", b_pop, 0);
    check("t1_awvalid", axi_awvalid, 1);
    check("t1_awaddr", axi_awaddr, 32'hDEAD0000);
    check("t1_awlen", axi_awlen, 4);
    check("t1_awsize", axi_awsize, 2);
    check("t1_awburst", axi_awburst, 1);
    check("t1_busy", busy, 1);
    axi_awready = 1'b1;
    tick();
    axi_awready = 1'b0;
    check("t1_pk_start", pk_start, 1);
    check("t1_pk_beats", pk_beats, 5);
    check("t1_out1", outstanding, 1);
    check("t1_awvalid_drop", axi_awvalid, 0);
    for (int i = 1; i <= 5; i++) begin
      axi_wvalid = 1'b1; axi_wready = 1'b1; axi_wlast = (i == 5);
      tick();
      if (i == 1) check("t1_pk_pulse", pk_start, 0);
    end
    set_w(1'b0);
    check("t1_sticky", err_sticky, 0);
    check("t1_bready", axi_bready, 1);
    axi_bvalid = 1'b1; axi_bresp = 2'b00;
    tick();
    axi_bvalid = 1'b0;
    check("t1_out0", outstanding, 0);
    check("t1_busy_end", busy, 0);
    check("t1_sticky_end", err_sticky, 0);

    // AW backpressure
    push(32'hA0000010, 12'h103);
    check("t2_pop", b_pop, 1);
    tick();
    for (int i = 0; i < 6; i++) begin
      tick();
      check("t2_awvalid", axi_awvalid, 1);
      check("t2_aw_fields", {axi_awaddr[15:0], axi_awlen, 5'd0, axi_awsize}, {16'h0010, 8'd3, 8'd1});
      check("t2_no_pk", pk_start, 0);
    end
    axi_awready = 1'b1;
    tick();
    axi_awready = 1'b0;
    check("t2_pk_start", pk_start, 1);
    check("t2_pk_beats", pk_beats, 4);
    for (int i = 1; i <= 4; i++) begin
      axi_wvalid = 1'b1; axi_wready = 1'b1; axi_wlast = (i == 4);
      tick();
    end
    set_w(1'b0);
    axi_bvalid = 1'b1;
    tick();
    axi_bvalid = 1'b0;
    check("t2_out0", outstanding, 0);
    check("t2_sticky", err_sticky, 0);

    // outstanding limit with 6 single-beat descriptors
    pop_base = pop_cnt; aw_base = aw_cnt;
    for (int i = 0; i < 6; i++) push(32'h0000_1000 + 32'(i) * 32'h40, 12'h000);
    axi_awready = 1'b1; set_w(1'b1);
    for (int i = 0; i < 6; i++) tick();
    check("t3_spacing_a", pop_cnt - pop_base, 2);
    tick();
    check("t3_spacing_b", pop_cnt - pop_base, 3);
    for (int i = 0; i < 13; i++) tick();
    check("t3_aw_count", aw_cnt - aw_base, 4);
    check("t3_pop_count", pop_cnt - pop_base, 4);
    check("t3_out4", outstanding, 4);
    check("t3_not_empty", b_empty, 0);
    check("t3_no_pop", b_pop, 0);
    check("t3_sticky", err_sticky, 0);
    axi_bvalid = 1'b1;
    tick();
    axi_bvalid = 1'b0;
    check("t3_out3", outstanding, 3);
    check("t3_pop_after_b", b_pop, 1);
    tick(); tick(); tick();
    check("t3_out4_again", outstanding, 4);
    check("t3_pop5", pop_cnt - pop_base, 5);

    // AW and B handshakes in the same cycle
    axi_awready = 1'b0; set_w(1'b0);
    axi_bvalid = 1'b1;
    tick();
    check("t4_out3", outstanding, 3);
    check("t4_pop", b_pop, 1);
    tick();
    check("t4_out2", outstanding, 2);
    check("t4_awvalid", axi_awvalid, 1);
    axi_awready = 1'b1;
    tick();
    check("t4_out_same", outstanding, 2);
    check("t4_pk_start", pk_start, 1);
    axi_bvalid = 1'b0; axi_awready = 1'b0;
    set_w(1'b1);
    tick();
    set_w(1'b0);
    check("t4_sticky", err_sticky, 0);

    // bad B responses, clear coinciding with an error
    push(32'h0000_2000, 12'h000);
    push(32'h0000_2040, 12'h000);
    axi_awready = 1'b1; set_w(1'b1);
    for (int i = 0; i < 6; i++) tick();
    axi_awready = 1'b0; set_w(1'b0);
    check("t5_out4", outstanding, 4);
    axi_bvalid = 1'b1; axi_bresp = 2'b10;
    for (int i = 1; i <= 3; i++) begin
      tick();
      check("t5_err_cnt", err_cnt, 32'(i));
      check("t5_sticky", err_sticky, 1);
    end
    clr_err = 1'b1;
    tick();
    check("t5_clr_cnt", err_cnt, 1);
    check("t5_clr_sticky", err_sticky, 1);
    check("t5_out0", outstanding, 0);
    axi_bvalid = 1'b0; axi_bresp = 2'b00;
    tick();
    clr_err = 1'b0;
    check("t5_cleared", {err_sticky, err_cnt}, 0);
    axi_bvalid = 1'b1;
    #1;
    check("t5_no_bready", axi_bready, 0);
    tick();
    axi_bvalid = 1'b0;
    check("t5_unexp_sticky", err_sticky, 1);
    check("t5_unexp_cnt", err_cnt, 0);
    check("t5_unexp_out", outstanding, 0);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;

    // early wlast, then reset mid-ADDR
    push(32'h0000_3000, 12'h003);
    tick();
    axi_awready = 1'b1;
    tick();
    axi_awready = 1'b0;
    axi_wvalid = 1'b1; axi_wready = 1'b1; axi_wlast = 1'b0;
    tick();
    axi_wlast = 1'b1;
    tick();
    set_w(1'b0);
    check("t6_sticky", err_sticky, 1);
    push(32'h0000_4000, 12'h000);
    check("t6_idle_pop", b_pop, 1);
    tick();
    check("t6_awvalid", axi_awvalid, 1);
    check("t6_awaddr", axi_awaddr, 32'h0000_4000);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("t6_rst_awvalid", axi_awvalid, 0);
    check("t6_rst_awburst", axi_awburst, 1);
    check("t6_rst_out", outstanding, 0);
    check("t6_rst_err", {err_sticky, err_cnt}, 0);
    check("t6_rst_aw", {axi_awaddr, axi_awlen}, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_pop", b_pop, 0);
    check("t6_rst_bready", axi_bready, 0);

    // beat count reached without wlast
    push(32'h0000_5000, 12'h001);
    tick();
    axi_awready = 1'b1;
    tick();
    axi_awready = 1'b0;
    check("t7_pk_beats", pk_beats, 2);
    axi_wvalid = 1'b1; axi_wready = 1'b1; axi_wlast = 1'b0;
    tick();
    check("t7_sticky_b1", err_sticky, 0);
    tick();
    check("t7_sticky_b2", err_sticky, 1);
    axi_wlast = 1'b1;
    tick();
    set_w(1'b0);
    axi_bvalid = 1'b1;
    tick();
    axi_bvalid = 1'b0;
    check("t7_out0", outstanding, 0);
    check("t7_busy", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
